mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 7 +
 rtl/arb_pick.sv | 20 ++
 rtl/mem_arbiter.sv | 90 +++++++++
 tb/tb_mem_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for mem_arbiter and arb_pick
package mem_arb_pkg;
  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;
  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational two-way winner select, one-hot {dm, if}.
// Round-robin against the last winner when MEM_ARB_RR_EN is defined, DM priority otherwise.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic       if_req_i,
  input  logic       dm_req_i,
  input  owner_t     last_i,
  output logic [1:0] win_o
);
  logic pick_dm;
`ifdef MEM_ARB_RR_EN
  assign pick_dm = dm_req_i && (!if_req_i || last_i == OWN_IF);
`else
  logic unused_last;
  assign unused_last = last_i;
  assign pick_dm = dm_req_i;
`endif
  assign win_o = {pick_dm, if_req_i && !pick_dm};
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data ports, one access outstanding.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; default is fixed DM priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [DW-1:0]   if_rdata_o,
  input  logic            dm_req_i,
  input  logic            dm_we_i,
  input  logic [AW-1:0]   dm_addr_i,
  input  logic [DW-1:0]   dm_wdata_i,
  input  logic [DW/8-1:0] dm_be_i,
  output logic            dm_gnt_o,
  output logic            dm_rvalid_o,
  output logic [DW-1:0]   dm_rdata_o,
  output logic            mem_ce_o,
  output logic            mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  output logic [DW/8-1:0] mem_be_o,
  input  logic [DW-1:0]   mem_rdata_i
);
  localparam int CW = $clog2(MEM_LAT + 1);
  state_t        state_q, state_d;
  owner_t        owner_q, owner_d, last_w;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic          resp, gnt_ok, any_gnt;
  logic [1:0]    win;
`ifdef MEM_ARB_RR_EN
  owner_t last_q, last_d;
  assign last_w = last_q;
  assign last_d = any_gnt ? owner_d : last_q;
  always_ff @(posedge clk) begin
    if (!rst) last_q <= OWN_DM;
    else      last_q <= last_d;
  end
`else
  assign last_w = OWN_DM;
`endif
  // cnt_q reaching 1 marks the cycle the outstanding response returns
  assign resp   = rst && state_q == WAIT && cnt_q == CW'(1);
  assign gnt_ok = rst && (state_q == IDLE || resp);
  arb_pick u_pick (
    .if_req_i (if_req_i && gnt_ok),
    .dm_req_i (dm_req_i && gnt_ok),
    .last_i   (last_w),
    .win_o    (win)
  );
  assign any_gnt     = |win;
  assign if_gnt_o    = win[0];
  assign dm_gnt_o    = win[1];
  assign mem_ce_o    = any_gnt;
  assign mem_we_o    = win[1] && dm_we_i;
  assign mem_addr_o  = win[1] ? dm_addr_i : win[0] ? if_addr_i : '0;
  assign mem_wdata_o = win[1] ? dm_wdata_i : '0;
  assign mem_be_o    = win[1] ? dm_be_i : {(DW/8){win[0]}};
  assign if_rvalid_o = resp && owner_q == OWN_IF;
  assign dm_rvalid_o = resp && owner_q == OWN_DM;
  assign if_rdata_o  = (if_rvalid_o && !wr_q) ? mem_rdata_i : '0;
  assign dm_rdata_o  = (dm_rvalid_o && !wr_q) ? mem_rdata_i : '0;
  always_comb begin
    state_d = any_gnt ? WAIT : resp ? IDLE : state_q;
    cnt_d   = any_gnt ? CW'(MEM_LAT) : state_q == WAIT ? cnt_q - CW'(1) : cnt_q;
    owner_d = any_gnt ? (win[1] ? OWN_DM : OWN_IF) : owner_q;
    wr_d    = any_gnt ? mem_we_o : wr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= OWN_IF;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: three arbiters (MEM_LAT 1..3) checked every cycle against a rule-level model
module tb_mem_arbiter;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic        if_req [3], dm_req [3], dm_we [3];
  logic [31:0] if_addr [3], dm_addr [3], dm_wdata [3], mem_rdata [3];
  logic [3:0]  dm_be [3], mem_be [3];
  logic        if_gnt [3], if_rvalid [3], dm_gnt [3], dm_rvalid [3], mem_ce [3], mem_we [3];
  logic [31:0] if_rdata [3], dm_rdata [3], mem_addr [3], mem_wdata [3];
  logic [31:0] mem [3][64];
  logic [31:0] rdq [3][4];
  logic [31:0] exp_data [3];
  int          due [3];
  bit          own_dm [3], last_dm [3], gi [3], gd [3];
  int          cyc, n_pass, n_tot;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign mem_rdata[g] = rdq[g][g];
    mem_arbiter #(.MEM_LAT(g + 1)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .if_req_i    (if_req[g]),
      .if_addr_i   (if_addr[g]),
      .if_gnt_o    (if_gnt[g]),
      .if_rvalid_o (if_rvalid[g]),
      .if_rdata_o  (if_rdata[g]),
      .dm_req_i    (dm_req[g]),
      .dm_we_i     (dm_we[g]),
      .dm_addr_i   (dm_addr[g]),
      .dm_wdata_i  (dm_wdata[g]),
      .dm_be_i     (dm_be[g]),
      .dm_gnt_o    (dm_gnt[g]),
      .dm_rvalid_o (dm_rvalid[g]),
      .dm_rdata_o  (dm_rdata[g]),
      .mem_ce_o    (mem_ce[g]),
      .mem_we_o    (mem_we[g]),
      .mem_addr_o  (mem_addr[g]),
      .mem_wdata_o (mem_wdata[g]),
      .mem_be_o    (mem_be[g]),
      .mem_rdata_i (mem_rdata[g])
    );
  end

  task automatic chkw(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s[lat%0d] cyc=%0d got=%h exp=%h", tag, g + 1, cyc, obs, exp);
  endtask

  task automatic chk1(input string tag, input int g, input logic obs, input logic exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s[lat%0d] cyc=%0d got=%b exp=%b", tag, g + 1, cyc, obs, exp);
  endtask

  // Model: a grant is allowed when nothing is outstanding or its response is due this cycle
  task automatic check_upd(input int g);
    bit busy, resp, ok, wi, wd, ev_if, ev_dm;
    logic [31:0] ea, rd;
    busy  = due[g] > cyc;
    resp  = due[g] == cyc;
    ok    = rst && !busy;
    wd    = ok && dm_req[g] && !(RR && if_req[g] && last_dm[g]);
    wi    = ok && if_req[g] && !wd;
    ea    = wd ? dm_addr[g] : wi ? if_addr[g] : 32'h0;
    ev_if = rst && resp && !own_dm[g];
    ev_dm = rst && resp && own_dm[g];
    chk1("if_gnt", g, if_gnt[g], wi);
    chk1("dm_gnt", g, dm_gnt[g], wd);
    chk1("mem_ce", g, mem_ce[g], wi || wd);
    chk1("mem_we", g, mem_we[g], wd && dm_we[g]);
    chkw("mem_addr", g, mem_addr[g], ea);
    chkw("mem_wdata", g, mem_wdata[g], wd ? dm_wdata[g] : 32'h0);
    chkw("mem_be", g, 32'(mem_be[g]), wd ? 32'(dm_be[g]) : wi ? 32'hF : 32'h0);
    chk1("if_rvalid", g, if_rvalid[g], ev_if);
    chkw("if_rdata", g, if_rdata[g], ev_if ? exp_data[g] : 32'h0);
    chk1("dm_rvalid", g, dm_rvalid[g], ev_dm);
    chkw("dm_rdata", g, dm_rdata[g], ev_dm ? exp_data[g] : 32'h0);
    rd = mem[g][ea[7:2]];
    for (int k = 3; k > 0; k--) rdq[g][k] = rdq[g][k-1];
    rdq[g][0] = (wi || (wd && !dm_we[g])) ? rd : $urandom;
    if (wd && dm_we[g])
      for (int b = 0; b < 4; b++)
        if (dm_be[g][b]) mem[g][ea[7:2]][8*b +: 8] = dm_wdata[g][8*b +: 8];
    if (!rst) begin
      due[g] = -1;
      last_dm[g] = 1'b1;
    end else if (wi || wd) begin
      due[g] = cyc + g + 1;
      own_dm[g] = wd;
      exp_data[g] = (wd && dm_we[g]) ? 32'h0 : rd;
      last_dm[g] = wd;
    end
    gi[g] = wi;
    gd[g] = wd;
  endtask

  task automatic step();
    #1;
    for (int g = 0; g < 3; g++) check_upd(g);
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [31:0] raddr();
    return {24'd0, 6'($urandom_range(0, 63)), 2'b00};
  endfunction

  initial begin
    rst = 1'b0;
    cyc = 0;
    n_pass = 0;
    n_tot = 0;
    for (int g = 0; g < 3; g++) begin
      if_req[g] = 1'b1;
      dm_req[g] = 1'b1;
      dm_we[g] = 1'b0;
      if_addr[g] = 32'h4;
      dm_addr[g] = 32'h8;
      dm_wdata[g] = 32'h0;
      dm_be[g] = 4'hF;
      due[g] = -1;
      own_dm[g] = 1'b0;
      last_dm[g] = 1'b1;
      exp_data[g] = 32'h0;
      for (int k = 0; k < 4; k++) rdq[g][k] = 32'h0;
      for (int i = 0; i < 64; i++) mem[g][i] = $urandom;
    end
    mem[1][4] = 32'h0;
    @(negedge clk);
    repeat (3) step();
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      if_req[g] = 1'b0;
      dm_req[g] = 1'b0;
    end
    step();
    if_req[1] = 1'b1;
    if_addr[1] = 32'h20;
    dm_req[1] = 1'b1;
    dm_addr[1] = 32'h30;
    for (int i = 0; i < 3; i++) begin
      if_req[0] = 1'b1;
      if_addr[0] = 32'(i * 4);
      step();
    end
    if_req[0] = 1'b0;
    repeat (6) step();
    if_req[1] = 1'b0;
    dm_req[1] = 1'b0;
    repeat (2) step();
    dm_req[1] = 1'b1;
    dm_we[1] = 1'b1;
    dm_addr[1] = 32'h10;
    dm_wdata[1] = 32'hDEADBEEF;
    dm_be[1] = 4'b0011;
    step();
    dm_req[1] = 1'b0;
    dm_we[1] = 1'b0;
    repeat (2) step();
    dm_req[1] = 1'b1;
    step();
    dm_req[1] = 1'b0;
    step();
    #1;
    chkw("wr_readback", 1, dm_rdata[1], 32'h0000BEEF);
    step();
    if_req[2] = 1'b1;
    if_addr[2] = 32'h40;
    step();
    if_req[2] = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    repeat (5) step();
    for (int n = 0; n < 400; n++) begin
      for (int g = 0; g < 3; g++) begin
        if (!if_req[g] || gi[g]) begin
          if_req[g] = 1'($urandom_range(0, 1));
          if_addr[g] = raddr();
        end
        if (!dm_req[g] || gd[g]) begin
          dm_req[g] = 1'($urandom_range(0, 1));
          dm_we[g] = 1'($urandom_range(0, 1));
          dm_addr[g] = raddr();
          dm_wdata[g] = $urandom;
          dm_be[g] = 4'($urandom_range(0, 15));
        end
      end
      step();
    end
    for (int g = 0; g < 3; g++) begin
      if_req[g] = 1'b0;
      dm_req[g] = 1'b0;
    end
    repeat (5) step();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
